// File: rtl/mem_stage_pkg.sv
// Shared opcodes, state encoding and constants for the memory-access stage.
// The ABORT state exists only when MEM_TIMEOUT_EN is defined.
package mem_stage_pkg;

  localparam int          DATA_W = 32;
  localparam logic [4:0]  OP_LW  = 5'b01000;
  localparam logic [4:0]  OP_SW  = 5'b00111;
  localparam logic [31:0] NOP_IR = 32'h0000_0000;

`ifdef MEM_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ABORT} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT} state_t;
`endif

  function automatic logic is_lw_op(input logic [31:0] ir);
    return ir[31:27] == OP_LW;
  endfunction

  function automatic logic is_sw_op(input logic [31:0] ir);
    return ir[31:27] == OP_SW;
  endfunction

endpackage

// File: rtl/mem_wdog.sv
// Clearable wait-cycle counter; expire pulses on the tick that would reach LIMIT.
// Instantiated by mem_access_stage only when MEM_TIMEOUT_EN is defined.
module mem_wdog #(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= 8'd0;
    else if (clear)
      count <= 8'd0;
    else if (tick)
      count <= count + 8'd1;
  end

  assign expire = tick && (count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// M-stage of the pipeline: issues lw/sw to data memory, stalls until ack and
// feeds the M/W latch. Define MEM_TIMEOUT_EN to enable the ack timeout/abort path.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] xm_o,
  input  logic [31:0] xm_b,
  input  logic [31:0] xm_ir,
  input  logic        xm_ovfl,
  input  logic        xm_valid,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] mw_o,
  output logic [31:0] mw_d,
  output logic [31:0] mw_ir,
  output logic        mw_ovfl,
  output logic        stall_out,
  output logic        mem_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_access_stage: TIMEOUT_CYCLES must be within 2..255");
  end

  state_t      state, state_next;
  logic        is_lw, is_sw, is_mem;
  logic        expire;
  logic [31:0] req_addr, req_wdata;
  logic        req_we;

  assign is_lw  = is_lw_op(xm_ir);
  assign is_sw  = is_sw_op(xm_ir);
  assign is_mem = xm_valid && (is_lw || is_sw);

`ifdef MEM_TIMEOUT_EN
  mem_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != ST_WAIT),
    .tick   ((state == ST_WAIT) && !dmem_ack),
    .expire (expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      mem_err <= 1'b0;
    else if ((state == ST_WAIT) && expire)
      mem_err <= 1'b1;
  end
`else
  assign expire  = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Request attributes are frozen at issue so WAIT cannot drift with the latch.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE) begin
      req_addr  <= xm_o;
      req_wdata <= xm_b;
      req_we    <= is_sw;
    end
  end

  always_comb begin
    state_next = state;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    mw_o       = 32'h0;
    mw_d       = 32'h0;
    mw_ir      = NOP_IR;
    mw_ovfl    = 1'b0;
    stall_out  = 1'b0;
    if (reset) begin
      case (state)
        ST_IDLE: begin
          if (is_mem) begin
            dmem_req   = 1'b1;
            dmem_we    = is_sw;
            dmem_addr  = xm_o;
            dmem_wdata = xm_b;
            if (dmem_ack) begin
              mw_o    = xm_o;
              mw_d    = is_lw ? dmem_rdata : xm_b;
              mw_ir   = xm_ir;
              mw_ovfl = xm_ovfl;
            end else begin
              stall_out  = 1'b1;
              state_next = ST_WAIT;
            end
          end else if (xm_valid) begin
            mw_o    = xm_o;
            mw_d    = xm_b;
            mw_ir   = xm_ir;
            mw_ovfl = xm_ovfl;
          end
        end
        ST_WAIT: begin
          dmem_req   = 1'b1;
          dmem_we    = req_we;
          dmem_addr  = req_addr;
          dmem_wdata = req_wdata;
          if (dmem_ack) begin
            mw_o       = xm_o;
            mw_d       = req_we ? xm_b : dmem_rdata;
            mw_ir      = xm_ir;
            mw_ovfl    = xm_ovfl;
            state_next = ST_IDLE;
          end else begin
            stall_out = 1'b1;
`ifdef MEM_TIMEOUT_EN
            if (expire)
              state_next = ST_ABORT;
`endif
          end
        end
`ifdef MEM_TIMEOUT_EN
        ST_ABORT: begin
          mw_o       = xm_o;
          mw_d       = 32'h0;
          mw_ir      = xm_ir;
          mw_ovfl    = 1'b1;
          state_next = ST_IDLE;
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage; expected M/W results are queued at issue
// and popped when the stage releases the instruction (stall_out low).
module tb_mem_access_stage;
  import mem_stage_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] xm_o, xm_b, xm_ir;
  logic        xm_ovfl, xm_valid;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [31:0] mw_o, mw_d, mw_ir;
  logic        mw_ovfl, stall_out, mem_err;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] o;
    logic [31:0] d;
    logic        ovfl;
    logic        req;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .xm_o(xm_o), .xm_b(xm_b), .xm_ir(xm_ir), .xm_ovfl(xm_ovfl), .xm_valid(xm_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mw_o(mw_o), .mw_d(mw_d), .mw_ir(mw_ir), .mw_ovfl(mw_ovfl),
    .stall_out(stall_out), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // ack_at: cycle index (0 = issue cycle) at which ack is driven, -1 for never.
  task automatic issue(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] b,
                       input logic ov, input int ack_at, input logic [31:0] rdata,
                       input int exp_stalls, input bit abort);
    exp_t e;
    int   stalls = 0;
    bit   done = 0;
    logic lw, sw;
    lw = (ir[31:27] == OP_LW);
    sw = (ir[31:27] == OP_SW);
    e.ir   = ir;
    e.o    = o;
    e.ovfl = abort ? 1'b1 : ov;
    e.d    = abort ? 32'h0 : (lw ? rdata : b);
    e.req  = (lw || sw) && !abort;
    sb.push_back(e);
    xm_ir = ir; xm_o = o; xm_b = b; xm_ovfl = ov; xm_valid = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      dmem_ack   = (k == ack_at);
      dmem_rdata = (k == ack_at) ? rdata : (32'hBAD0_0000 | 32'(k));
      @(negedge clock);
      if (stall_out) begin
        stalls++;
        check("bubble_ir", mw_ir, 32'h0);
        check("bubble_o", mw_o, 32'h0);
        check("bubble_d", mw_d, 32'h0);
        check("bubble_ovfl", 32'(mw_ovfl), 32'h0);
        check("wait_req", 32'(dmem_req), 32'h1);
        check("wait_we", 32'(dmem_we), 32'(sw));
        check("wait_addr", dmem_addr, o);
        check("wait_wdata", dmem_wdata, b);
      end else begin
        e = sb.pop_front();
        check("done_ir", mw_ir, e.ir);
        check("done_o", mw_o, e.o);
        check("done_d", mw_d, e.d);
        check("done_ovfl", 32'(mw_ovfl), 32'(e.ovfl));
        check("done_req", 32'(dmem_req), 32'(e.req));
        if (e.req) begin
          check("done_we", 32'(dmem_we), 32'(sw));
          check("done_addr", dmem_addr, o);
          check("done_wdata", dmem_wdata, b);
        end
        done = 1;
      end
      @(posedge clock); #1;
    end
    dmem_ack = 1'b0;
    check("completed", 32'(done), 32'h1);
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0;
    xm_ir = {OP_LW, 27'h10}; xm_o = 32'h10; xm_b = 32'h0; xm_ovfl = 1'b0; xm_valid = 1'b1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #12;
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_stall", 32'(stall_out), 32'h0);
    check("rst_err", 32'(mem_err), 32'h0);
    check("rst_mw_ir", mw_ir, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    issue(32'h0000_1234, 32'd5, 32'd7, 1'b0, 0, 32'h0, 0, 0);
    issue({5'b00001, 27'h0ABC}, 32'h8000_0000, 32'h77, 1'b1, -1, 32'h0, 0, 0);
    issue({OP_LW, 27'h10}, 32'h10, 32'h55, 1'b0, 0, 32'hDEAD_BEEF, 0, 0);
    issue({OP_SW, 27'h20}, 32'h20, 32'hCAFE_F00D, 1'b0, 3, 32'h1111_2222, 3, 0);
    issue({OP_LW, 27'h30}, 32'h30, 32'h99, 1'b1, 2, 32'h1357_9BDF, 2, 0);
    issue({OP_LW, 27'h40}, 32'h40, 32'h1, 1'b0, 1, 32'hAAAA_0001, 1, 0);
    issue({OP_LW, 27'h44}, 32'h44, 32'h2, 1'b0, 1, 32'hAAAA_0002, 1, 0);

    xm_valid = 1'b0; xm_ir = {OP_SW, 27'h5}; xm_o = 32'h5; dmem_ack = 1'b1;
    @(negedge clock);
    check("inv_req", 32'(dmem_req), 32'h0);
    check("inv_stall", 32'(stall_out), 32'h0);
    check("inv_mw_ir", mw_ir, 32'h0);
    check("inv_mw_o", mw_o, 32'h0);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    issue({OP_SW, 27'h50}, 32'h50, 32'h5050, 1'b0, 2, 32'h0, 2, 0);

`ifdef MEM_TIMEOUT_EN
    issue({OP_LW, 27'h60}, 32'h60, 32'h0, 1'b0, TO, 32'h6060_6060, TO, 0);
    check("tie_err", 32'(mem_err), 32'h0);
    issue({OP_LW, 27'h70}, 32'h70, 32'h0, 1'b0, -1, 32'h0, TO + 1, 1);
    check("abort_err", 32'(mem_err), 32'h1);
    issue(32'h0000_0042, 32'h42, 32'h43, 1'b0, -1, 32'h0, 0, 0);
    check("err_sticky", 32'(mem_err), 32'h1);
`else
    issue({OP_LW, 27'h60}, 32'h60, 32'h0, 1'b0, 20, 32'h6060_6060, 20, 0);
    check("no_err", 32'(mem_err), 32'h0);
`endif

    xm_ir = {OP_LW, 27'h80}; xm_o = 32'h80; xm_b = 32'h0; xm_valid = 1'b1; dmem_ack = 1'b0;
    @(negedge clock);
    check("pre_rst_stall", 32'(stall_out), 32'h1);
    @(posedge clock); #1;
    @(negedge clock);
    check("pre_rst_req", 32'(dmem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("midrst_req", 32'(dmem_req), 32'h0);
    check("midrst_stall", 32'(stall_out), 32'h0);
    check("midrst_mw_ir", mw_ir, 32'h0);
    check("midrst_err", 32'(mem_err), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    issue({OP_LW, 27'h90}, 32'h90, 32'h0, 1'b0, 1, 32'h0BAD_CAFE, 1, 0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
